// File: rtl/fifo_ctrl_pkg.sv
// Shared types and pointer-comparison helpers for the FIFO level controller.
// Helpers take zero-extended pointers so they stay independent of ADDR_WIDTH.
package fifo_ctrl_pkg;

    // Widest pointer the helpers accept (ADDR_WIDTH up to 16).
    localparam int unsigned MAX_PTR_W = 17;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // Pointers are equal including the wrap bit: nothing stored.
    function automatic logic ptr_empty(input logic [MAX_PTR_W-1:0] wptr,
                                       input logic [MAX_PTR_W-1:0] rptr);
        return (wptr == rptr);
    endfunction

    // Low bits equal, wrap bits differ. wrap_bit holds DEPTH, i.e. the one-hot
    // position of the wrap bit, so XOR of the pointers must equal exactly it.
    function automatic logic ptr_full(input logic [MAX_PTR_W-1:0] wptr,
                                      input logic [MAX_PTR_W-1:0] rptr,
                                      input logic [MAX_PTR_W-1:0] wrap_bit);
        return ((wptr ^ rptr) == wrap_bit);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap counter used for both FIFO pointers: the MSB is the wrap bit and the
// counter rolls over naturally at 2**WIDTH.
module fifo_ptr #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] ptr_o
);

    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] ptr_d;

    // Next pointer: flush wins over increment.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + WIDTH'(1);
        end
    end

    // Pointer register with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_level_controller.sv
// FIFO pointer/occupancy controller for an external synchronous-read RAM.
// Produces RAM addresses and enables, a registered fill count, programmable
// almost-full/almost-empty flags, sticky error flags, a synchronous flush and
// a read-data-valid strobe delayed by the RAM read latency.
//
// Handshake: a write is performed (out_wr_accept) in the cycle in_wen is high,
// the FIFO is not full and no flush is requested; a read likewise needs in_ren,
// not empty and no flush. Requests that are not accepted are simply dropped and
// raise the corresponding sticky error flag.
module fifo_level_controller
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_clr,
    input  logic                  in_wen,
    input  logic                  in_ren,
    input  logic [ADDR_WIDTH:0]   in_af_thresh,
    input  logic [ADDR_WIDTH:0]   in_ae_thresh,
    input  logic                  in_err_clr,
    output logic [ADDR_WIDTH-1:0] out_waddr,
    output logic [ADDR_WIDTH-1:0] out_raddr,
    output logic                  out_wr_accept,
    output logic                  out_rd_accept,
    output logic                  out_rvalid,
    output logic [ADDR_WIDTH:0]   out_count,
    output logic                  out_empty,
    output logic                  out_full,
    output logic                  out_almost_empty,
    output logic                  out_almost_full,
    output logic                  out_overflow,
    output logic                  out_underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic                  ptr_is_empty;
    logic                  ptr_is_full;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [PTR_W-1:0]      count_q;
    logic [PTR_W-1:0]      count_d;
    logic [PTR_W-1:0]      af_eff;
    logic [RD_LATENCY-1:0] rvalid_shift;
    logic [RD_LATENCY-1:0] rvalid_q;
    logic [RD_LATENCY-1:0] rvalid_d;
    logic                  ovf_q;
    logic                  ovf_d;
    logic                  unf_q;
    logic                  unf_d;
    fifo_status_t          status;

    assign ptr_is_empty = ptr_empty(MAX_PTR_W'(wptr), MAX_PTR_W'(rptr));
    assign ptr_is_full  = ptr_full(MAX_PTR_W'(wptr), MAX_PTR_W'(rptr), MAX_PTR_W'(DEPTH));

    // Full blocks writes and empty blocks reads, so simultaneous requests never
    // pass data through an empty FIFO or overwrite a full one.
    assign wr_accept = in_wen & ~ptr_is_full  & ~in_clr;
    assign rd_accept = in_ren & ~ptr_is_empty & ~in_clr;

    fifo_ptr #(.WIDTH(PTR_W)) u_wptr (
        .clk_i   (in_clk),
        .rst_n_i (in_rst_n),
        .inc_i   (wr_accept),
        .clr_i   (in_clr),
        .ptr_o   (wptr)
    );

    fifo_ptr #(.WIDTH(PTR_W)) u_rptr (
        .clk_i   (in_clk),
        .rst_n_i (in_rst_n),
        .inc_i   (rd_accept),
        .clr_i   (in_clr),
        .ptr_o   (rptr)
    );

    // Read-accept shifted one stage per cycle; the last stage is the strobe.
    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign rvalid_shift = rd_accept;
        end else begin : g_latn
            assign rvalid_shift = {rvalid_q[RD_LATENCY-2:0], rd_accept};
        end
    endgenerate

    // Next count, rvalid pipeline and sticky errors; a new error beats err_clr.
    always_comb begin
        count_d = count_q;
        if (in_clr) begin
            count_d = '0;
        end else if (wr_accept && !rd_accept) begin
            count_d = count_q + PTR_W'(1);
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - PTR_W'(1);
        end

        rvalid_d = in_clr ? '0 : rvalid_shift;

        ovf_d = ovf_q;
        if (in_wen && ptr_is_full && !in_clr) begin
            ovf_d = 1'b1;
        end else if (in_err_clr) begin
            ovf_d = 1'b0;
        end

        unf_d = unf_q;
        if (in_ren && ptr_is_empty && !in_clr) begin
            unf_d = 1'b1;
        end else if (in_err_clr) begin
            unf_d = 1'b0;
        end
    end

    // Count, rvalid pipeline and error flag registers.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            count_q  <= '0;
            rvalid_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // A zero almost-full threshold means "only when completely full".
    assign af_eff = (in_af_thresh == '0) ? PTR_W'(DEPTH) : in_af_thresh;

    // Status flags gathered in one struct.
    always_comb begin
        status.empty        = ptr_is_empty;
        status.full         = ptr_is_full;
        status.almost_empty = (count_q <= in_ae_thresh);
        status.almost_full  = (count_q >= af_eff);
        status.overflow     = ovf_q;
        status.underflow    = unf_q;
    end

    assign out_waddr        = wptr[ADDR_WIDTH-1:0];
    assign out_raddr        = rptr[ADDR_WIDTH-1:0];
    assign out_wr_accept    = wr_accept;
    assign out_rd_accept    = rd_accept;
    assign out_rvalid       = rvalid_q[RD_LATENCY-1];
    assign out_count        = count_q;
    assign out_empty        = status.empty;
    assign out_full         = status.full;
    assign out_almost_empty = status.almost_empty;
    assign out_almost_full  = status.almost_full;
    assign out_overflow     = status.overflow;
    assign out_underflow    = status.underflow;

endmodule

// File: tb/tb_fifo_level_controller.sv
// Bench for fifo_level_controller (ADDR_WIDTH=2, RD_LATENCY=1).
module tb_fifo_level_controller;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    // clock / reset
    logic          in_clk = 1'b0;
    logic          in_rst_n = 1'b0;
    logic          in_clr = 1'b0;
    logic          in_wen = 1'b0;
    logic          in_ren = 1'b0;
    logic [AW:0]   in_af_thresh = 3'd3;
    logic [AW:0]   in_ae_thresh = 3'd1;
    logic          in_err_clr = 1'b0;
    logic [AW-1:0] out_waddr;
    logic [AW-1:0] out_raddr;
    logic          out_wr_accept;
    logic          out_rd_accept;
    logic          out_rvalid;
    logic [AW:0]   out_count;
    logic          out_empty;
    logic          out_full;
    logic          out_almost_empty;
    logic          out_almost_full;
    logic          out_overflow;
    logic          out_underflow;

    always #5 in_clk = ~in_clk;

    fifo_level_controller #(.ADDR_WIDTH(AW), .RD_LATENCY(1)) dut (
        .in_clk           (in_clk),
        .in_rst_n         (in_rst_n),
        .in_clr           (in_clr),
        .in_wen           (in_wen),
        .in_ren           (in_ren),
        .in_af_thresh     (in_af_thresh),
        .in_ae_thresh     (in_ae_thresh),
        .in_err_clr       (in_err_clr),
        .out_waddr        (out_waddr),
        .out_raddr        (out_raddr),
        .out_wr_accept    (out_wr_accept),
        .out_rd_accept    (out_rd_accept),
        .out_rvalid       (out_rvalid),
        .out_count        (out_count),
        .out_empty        (out_empty),
        .out_full         (out_full),
        .out_almost_empty (out_almost_empty),
        .out_almost_full  (out_almost_full),
        .out_overflow     (out_overflow),
        .out_underflow    (out_underflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, addresses from running totals.
    int m_q[$];
    int m_wr_n = 0;
    int m_rd_n = 0;
    bit m_rv   = 0;
    bit m_ovf  = 0;
    bit m_unf  = 0;

    task automatic model_reset();
        m_q.delete();
        m_wr_n = 0;
        m_rd_n = 0;
        m_rv   = 0;
        m_ovf  = 0;
        m_unf  = 0;
    endtask

    function automatic bit m_full();
        return m_q.size() == DEPTH;
    endfunction

    function automatic bit m_empty();
        return m_q.size() == 0;
    endfunction

    function automatic bit m_wacc();
        return in_wen && !m_full() && !in_clr;
    endfunction

    function automatic bit m_racc();
        return in_ren && !m_empty() && !in_clr;
    endfunction

    task automatic model_check(input string tag);
        int afe;
        afe = (in_af_thresh == 0) ? DEPTH : int'(in_af_thresh);
        chk({tag, ".wacc"},  out_wr_accept,    m_wacc());
        chk({tag, ".racc"},  out_rd_accept,    m_racc());
        chk({tag, ".count"}, out_count,        m_q.size());
        chk({tag, ".empty"}, out_empty,        m_empty());
        chk({tag, ".full"},  out_full,         m_full());
        chk({tag, ".ae"},    out_almost_empty, m_q.size() <= int'(in_ae_thresh));
        chk({tag, ".af"},    out_almost_full,  m_q.size() >= afe);
        chk({tag, ".waddr"}, out_waddr,        m_wr_n % DEPTH);
        chk({tag, ".raddr"}, out_raddr,        m_rd_n % DEPTH);
        chk({tag, ".rvalid"}, out_rvalid,      m_rv);
        chk({tag, ".ovf"},   out_overflow,     m_ovf);
        chk({tag, ".unf"},   out_underflow,    m_unf);
    endtask

    task automatic model_update();
        bit wa, ra, ov, un;
        wa = m_wacc();
        ra = m_racc();
        ov = in_wen && m_full() && !in_clr;
        un = in_ren && m_empty() && !in_clr;
        if (in_clr) begin
            m_q.delete();
            m_wr_n = 0;
            m_rd_n = 0;
            m_rv   = 0;
        end else begin
            if (ra) begin
                void'(m_q.pop_front());
                m_rd_n++;
            end
            if (wa) begin
                m_q.push_back(m_wr_n);
                m_wr_n++;
            end
            m_rv = ra;
        end
        if (ov) m_ovf = 1;
        else if (in_err_clr) m_ovf = 0;
        if (un) m_unf = 1;
        else if (in_err_clr) m_unf = 0;
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge,
    // outputs are sampled at the falling edge
    task automatic apply(input bit wen, input bit ren, input bit clr, input bit eclr, input string tag);
        in_wen     = wen;
        in_ren     = ren;
        in_clr     = clr;
        in_err_clr = eclr;
        @(negedge in_clk);
        model_check(tag);
    endtask

    task automatic finish_cycle();
        model_update();
        @(posedge in_clk);
        #1;
    endtask

    task automatic cycle(input bit wen, input bit ren, input bit clr, input bit eclr, input string tag);
        apply(wen, ren, clr, eclr, tag);
        finish_cycle();
    endtask

    typedef struct {
        bit wen, ren, clr, eclr;
        bit wacc, racc;
        int cnt;
        bit emp, ful, ae, af;
        int wa, ra;
        bit rv, ovf, unf;
    } vec_t;

    function automatic vec_t mk(bit wen, bit ren, bit clr, bit eclr, bit wacc, bit racc, int cnt,
                                bit emp, bit ful, bit ae, bit af, int wa, int ra, bit rv, bit ovf, bit unf);
        vec_t v;
        v.wen = wen; v.ren = ren; v.clr = clr; v.eclr = eclr;
        v.wacc = wacc; v.racc = racc; v.cnt = cnt;
        v.emp = emp; v.ful = ful; v.ae = ae; v.af = af;
        v.wa = wa; v.ra = ra; v.rv = rv; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    vec_t vecs[14];

    initial begin
        string t;

        // fill / drain table, af=3 ae=1; expectations are pre-edge values
        vecs[0]  = mk(0,0,0,0, 0,0,0, 1,0,1,0, 0,0, 0,0,0);
        vecs[1]  = mk(1,0,0,0, 1,0,0, 1,0,1,0, 0,0, 0,0,0);
        vecs[2]  = mk(1,0,0,0, 1,0,1, 0,0,1,0, 1,0, 0,0,0);
        vecs[3]  = mk(1,0,0,0, 1,0,2, 0,0,0,0, 2,0, 0,0,0);
        vecs[4]  = mk(1,0,0,0, 1,0,3, 0,0,0,1, 3,0, 0,0,0);
        vecs[5]  = mk(1,0,0,0, 0,0,4, 0,1,0,1, 0,0, 0,0,0);
        vecs[6]  = mk(0,1,0,0, 0,1,4, 0,1,0,1, 0,0, 0,1,0);
        vecs[7]  = mk(0,1,0,0, 0,1,3, 0,0,0,1, 0,1, 1,1,0);
        vecs[8]  = mk(0,1,0,0, 0,1,2, 0,0,0,0, 0,2, 1,1,0);
        vecs[9]  = mk(0,1,0,0, 0,1,1, 0,0,1,0, 0,3, 1,1,0);
        vecs[10] = mk(0,1,0,0, 0,0,0, 1,0,1,0, 0,0, 1,1,0);
        vecs[11] = mk(0,0,0,0, 0,0,0, 1,0,1,0, 0,0, 0,1,1);
        vecs[12] = mk(0,0,0,1, 0,0,0, 1,0,1,0, 0,0, 0,1,1);
        vecs[13] = mk(0,0,0,0, 0,0,0, 1,0,1,0, 0,0, 0,0,0);

        // reset state
        model_reset();
        @(negedge in_clk);
        chk("reset.count", out_count, 0);
        chk("reset.empty", out_empty, 1);
        chk("reset.full",  out_full, 0);
        chk("reset.ae",    out_almost_empty, 1);
        chk("reset.af",    out_almost_full, 0);
        chk("reset.waddr", out_waddr, 0);
        chk("reset.raddr", out_raddr, 0);
        @(posedge in_clk);
        #1;
        in_rst_n = 1'b1;

        // table-driven fill/drain
        for (int i = 0; i < 14; i++) begin
            t = $sformatf("row%0d", i);
            apply(vecs[i].wen, vecs[i].ren, vecs[i].clr, vecs[i].eclr, t);
            chk({t, ".t_wacc"},  out_wr_accept,    vecs[i].wacc);
            chk({t, ".t_racc"},  out_rd_accept,    vecs[i].racc);
            chk({t, ".t_count"}, out_count,        vecs[i].cnt);
            chk({t, ".t_empty"}, out_empty,        vecs[i].emp);
            chk({t, ".t_full"},  out_full,         vecs[i].ful);
            chk({t, ".t_ae"},    out_almost_empty, vecs[i].ae);
            chk({t, ".t_af"},    out_almost_full,  vecs[i].af);
            chk({t, ".t_waddr"}, out_waddr,        vecs[i].wa);
            chk({t, ".t_raddr"}, out_raddr,        vecs[i].ra);
            chk({t, ".t_rvalid"}, out_rvalid,      vecs[i].rv);
            chk({t, ".t_ovf"},   out_overflow,     vecs[i].ovf);
            chk({t, ".t_unf"},   out_underflow,    vecs[i].unf);
            finish_cycle();
        end

        // simultaneous read/write at count 2 for 10 cycles
        cycle(1, 0, 0, 0, "sim_fill");
        cycle(1, 0, 0, 0, "sim_fill");
        for (int i = 0; i < 10; i++) begin
            apply(1, 1, 0, 0, "sim_rw");
            chk("sim_rw.count2", out_count, 2);
            chk("sim_rw.both", {out_wr_accept, out_rd_accept}, 2'b11);
            finish_cycle();
        end

        // empty with both requested: write only
        cycle(0, 0, 1, 1, "flush0");
        apply(1, 1, 0, 0, "empty_both");
        chk("empty_both.acc", {out_wr_accept, out_rd_accept}, 2'b10);
        finish_cycle();
        cycle(1, 0, 0, 0, "fill");
        cycle(1, 0, 0, 0, "fill");
        cycle(1, 0, 0, 0, "fill");

        // full with both requested: read only, overflow wins over err_clr
        apply(1, 1, 0, 1, "full_both");
        chk("full_both.acc", {out_wr_accept, out_rd_accept}, 2'b01);
        finish_cycle();
        apply(0, 0, 0, 0, "after_full_both");
        chk("after_full_both.ovf", out_overflow, 1);
        chk("after_full_both.unf", out_underflow, 0);
        chk("after_full_both.count", out_count, 3);
        finish_cycle();

        // flush at count 3 with a read in flight
        cycle(1, 1, 0, 0, "inflight");
        apply(1, 1, 1, 0, "flush");
        chk("flush.acc", {out_wr_accept, out_rd_accept}, 2'b00);
        chk("flush.rvalid_before", out_rvalid, 1);
        finish_cycle();
        apply(1, 1, 1, 0, "flush_empty");
        chk("flush.count", out_count, 0);
        chk("flush.empty", out_empty, 1);
        chk("flush.rvalid", out_rvalid, 0);
        chk("flush.ovf_kept", out_overflow, 1);
        finish_cycle();
        apply(0, 0, 0, 0, "post_flush");
        chk("post_flush.unf", out_underflow, 0);
        finish_cycle();
        cycle(0, 0, 0, 1, "errclr");
        apply(0, 0, 0, 0, "errclr_done");
        chk("errclr.ovf", out_overflow, 0);
        finish_cycle();

        // asynchronous reset mid-stream: count 2 and rvalid pending
        cycle(1, 0, 0, 0, "pre_rst");
        cycle(1, 0, 0, 0, "pre_rst");
        cycle(1, 0, 0, 0, "pre_rst");
        cycle(1, 1, 0, 0, "pre_rst_rd");
        cycle(0, 1, 0, 0, "pre_rst_rd");
        in_wen = 0;
        in_ren = 0;
        #2;
        chk("pre_rst.rvalid", out_rvalid, 1);
        chk("pre_rst.count", out_count, 2);
        in_rst_n = 1'b0;
        #1;
        chk("async_rst.count",  out_count, 0);
        chk("async_rst.empty",  out_empty, 1);
        chk("async_rst.rvalid", out_rvalid, 0);
        chk("async_rst.waddr",  out_waddr, 0);
        chk("async_rst.raddr",  out_raddr, 0);
        chk("async_rst.ae",     out_almost_empty, 1);
        chk("async_rst.af",     out_almost_full, 0);
        model_reset();
        @(posedge in_clk);
        #1;
        in_rst_n = 1'b1;

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                in_af_thresh = 3'($urandom_range(0, DEPTH));
                in_ae_thresh = 3'($urandom_range(0, DEPTH - 1));
            end
            cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                  1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 9) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
